// File: rtl/oib_link_arbiter.sv
// oib_link_arbiter: round-robin arbiter and byte serializer for the
// 8-bit odd-parity off-chip link shared by two Wishbone requesters.
module oib_link_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [3:0]  m0_sel,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack,
   output logic        m0_err,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m1_dat_o,
   output logic        oib_clk,
   output logic [7:0]  ob_data,
   output logic        ob_pty,
   input  logic [7:0]  ib_data,
   input  logic        ib_pty
);
   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE
   } state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t      state;
   logic        phase, last_grant, gid;
   logic        sh_we, done_ok, aborted;
   logic [3:0]  bcnt, nbytes;
   logic [7:0]  scnt, hdr, fbyte;
   logic [31:0] sh_adr, sh_dat, sh_rd;
   logic        req0, req1, pick, pick_we;
   logic        gcyc, ib_ok;
   logic [3:0]  pick_sel;

   // Request selection, header build and outbound byte mux
   always_comb begin
      req0     = m0_cyc & m0_stb;
      req1     = m1_cyc & m1_stb;
      pick     = (req0 & req1) ? ~last_grant : req1;
      pick_we  = pick ? m1_we : m0_we;
      pick_sel = pick ? m1_sel : m0_sel;
      hdr      = {pick_we, pick, pick_sel, 2'b01};
      gcyc     = gid ? m1_cyc : m0_cyc;
      ib_ok    = (ib_pty == ~^ib_data);
      nbytes   = sh_we ? 4'd9 : 4'd5;
      case (bcnt)
         4'd1:    fbyte = sh_adr[7:0];
         4'd2:    fbyte = sh_adr[15:8];
         4'd3:    fbyte = sh_adr[23:16];
         4'd4:    fbyte = sh_adr[31:24];
         4'd5:    fbyte = sh_dat[7:0];
         4'd6:    fbyte = sh_dat[15:8];
         4'd7:    fbyte = sh_dat[23:16];
         4'd8:    fbyte = sh_dat[31:24];
         default: fbyte = 8'h00;
      endcase
   end

   // Slot phase, link framing FSM and registered requester outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= S_IDLE;
         phase      <= 1'b0;
         oib_clk    <= 1'b0;
         ob_data    <= 8'h00;
         ob_pty     <= 1'b1;
         last_grant <= 1'b1;
         gid        <= 1'b0;
         sh_we      <= 1'b0;
         sh_adr     <= '0;
         sh_dat     <= '0;
         sh_rd      <= '0;
         bcnt       <= '0;
         scnt       <= '0;
         done_ok    <= 1'b0;
         aborted    <= 1'b0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_dat_o   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_dat_o   <= '0;
      end else begin
         phase   <= ~phase;
         oib_clk <= ~phase;
         m0_ack  <= 1'b0;
         m0_err  <= 1'b0;
         m1_ack  <= 1'b0;
         m1_err  <= 1'b0;
         if (state != S_IDLE && !gcyc)
            aborted <= 1'b1;
         case (state)
            S_IDLE: begin
               if (phase && (req0 | req1)) begin
                  gid        <= pick;
                  last_grant <= pick;
                  sh_we      <= pick_we;
                  sh_adr     <= pick ? m1_adr : m0_adr;
                  sh_dat     <= pick ? m1_dat_i : m0_dat_i;
                  ob_data    <= hdr;
                  ob_pty     <= ~^hdr;
                  bcnt       <= 4'd1;
                  aborted    <= 1'b0;
                  state      <= S_SEND;
               end
            end
            S_SEND: begin
               if (phase) begin
                  if (bcnt == nbytes) begin
                     ob_data <= 8'h00;
                     ob_pty  <= 1'b1;
                     scnt    <= 8'd0;
                     state   <= S_WAIT;
                  end else begin
                     ob_data <= fbyte;
                     ob_pty  <= ~^fbyte;
                     bcnt    <= bcnt + 4'd1;
                  end
               end
            end
            S_WAIT: begin
               if (phase) begin
                  if (!ib_ok) begin
                     done_ok <= 1'b0;
                     state   <= S_DONE;
                  end else if (ib_data == 8'h00) begin
                     scnt <= scnt + 8'd1;
                     if (scnt + 8'd1 == TMO) begin
                        done_ok <= 1'b0;
                        state   <= S_DONE;
                     end
                  end else if (ib_data == 8'h01) begin
                     if (sh_we) begin
                        done_ok <= 1'b1;
                        state   <= S_DONE;
                     end else begin
                        bcnt  <= 4'd0;
                        state <= S_RECV;
                     end
                  end else begin
                     done_ok <= 1'b0;
                     state   <= S_DONE;
                  end
               end
            end
            S_RECV: begin
               if (phase) begin
                  if (!ib_ok) begin
                     done_ok <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     sh_rd[{bcnt[1:0], 3'b000} +: 8] <= ib_data;
                     bcnt <= bcnt + 4'd1;
                     if (bcnt[1:0] == 2'd3) begin
                        done_ok <= 1'b1;
                        state   <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               if (!aborted && gcyc) begin
                  if (gid) begin
                     m1_ack <= done_ok;
                     m1_err <= ~done_ok;
                     if (done_ok && !sh_we)
                        m1_dat_o <= sh_rd;
                  end else begin
                     m0_ack <= done_ok;
                     m0_err <= ~done_ok;
                     if (done_ok && !sh_we)
                        m0_dat_o <= sh_rd;
                  end
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_oib_link_arbiter.sv
// tb_oib_link_arbiter: link responder plus transaction-level model
// of the arbiter, compared against the DUT every cycle.
module tb_oib_link_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
   logic [3:0]  m0_sel = 0;
   logic [31:0] m0_adr = 0, m0_dat_i = 0;
   logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
   logic [3:0]  m1_sel = 0;
   logic [31:0] m1_adr = 0, m1_dat_i = 0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_dat_o, m1_dat_o;
   logic        oib_clk, ob_pty;
   logic [7:0]  ob_data;
   logic [7:0]  ib_data = 8'h00;
   logic        ib_pty = 1'b1;

   oib_link_arbiter #(.TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we),
      .m0_sel(m0_sel), .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_o(m0_dat_o),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we),
      .m1_sel(m1_sel), .m1_adr(m1_adr), .m1_dat_i(m1_dat_i),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_o(m1_dat_o),
      .oib_clk(oib_clk), .ob_data(ob_data), .ob_pty(ob_pty),
      .ib_data(ib_data), .ib_pty(ib_pty)
   );

   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  nm, act, exp, cyc_n);
      end
   endtask

   // reply script for the next frame (snapshotted at frame start)
   logic [7:0]  rb[16];
   bit          rbad[16];
   int          rlen = 0;
   logic [7:0]  crb[16];
   bit          crbad[16];
   int          crlen = 0;

   // responder / model state
   int          fcnt = 0, fexp = 0, ridx = 0;
   logic [7:0]  fr[9], efr[9];
   bit          pend = 0, ab = 0, exp_ok = 0, exp_id = 0, exp_we = 0;
   int          done_at = 0, hdr_cyc = 0, done_cyc = 0;
   logic [31:0] exp_rd = 0, exp_d0 = 0, exp_d1 = 0;
   bit          last_g = 1, pr0 = 0, pr1 = 0;
   bit          gseq[$];
   int          n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0;

   task automatic predict(input bit we, input int c0);
      int t, idl, k;
      bit dec, rcv, bad;
      logic [7:0] b;
      t = c0 + 2 * (we ? 9 : 5);
      idl = 0; k = 0; dec = 0; rcv = 0;
      while (!dec) begin
         b   = (k < crlen) ? crb[k] : 8'h00;
         bad = (k < crlen) ? crbad[k] : 1'b0;
         k++; t += 2;
         if (bad) begin exp_ok = 0; dec = 1; end
         else if (b == 8'h00) begin
            idl++;
            if (idl == TO) begin exp_ok = 0; dec = 1; end
         end else if (b == 8'h01) begin
            dec = 1;
            if (we) exp_ok = 1; else rcv = 1;
         end else begin exp_ok = 0; dec = 1; end
      end
      if (rcv) begin
         exp_ok = 1;
         for (int j = 0; j < 4; j++) begin
            if (exp_ok) begin
               b   = (k < crlen) ? crb[k] : 8'h00;
               bad = (k < crlen) ? crbad[k] : 1'b0;
               k++; t += 2;
               if (bad) exp_ok = 0;
               else exp_rd[8*j +: 8] = b;
            end
         end
      end
      done_at = t + 1;
   endtask

   // responder and per-cycle comparison against the model
   always @(negedge clk) begin
      bit hit, ea0, ee0, ea1, ee1, eid, we;
      logic [3:0]  sel;
      logic [31:0] adr, dat;
      if (rst) begin
         fcnt = 0; fexp = 0; pend = 0; ab = 0; last_g = 1;
         exp_d0 = 0; exp_d1 = 0; pr0 = 0; pr1 = 0;
         ib_data = 8'h00; ib_pty = 1'b1;
      end else begin
         hit = pend && cyc_n == done_at && !ab;
         ea0 = hit && exp_ok && !exp_id;
         ee0 = hit && !exp_ok && !exp_id;
         ea1 = hit && exp_ok && exp_id;
         ee1 = hit && !exp_ok && exp_id;
         if (ea0 && !exp_we) exp_d0 = exp_rd;
         if (ea1 && !exp_we) exp_d1 = exp_rd;
         chk("ob_pty", ob_pty, ~^ob_data);
         chk("m0_ack", m0_ack, ea0);
         chk("m0_err", m0_err, ee0);
         chk("m1_ack", m1_ack, ea1);
         chk("m1_err", m1_err, ee1);
         chk("m0_dat_o", m0_dat_o, exp_d0);
         chk("m1_dat_o", m1_dat_o, exp_d1);
         if (m0_ack) n_ack0++;
         if (m0_err) n_err0++;
         if (m1_ack) n_ack1++;
         if (m1_err) n_err1++;
         if (m0_ack | m0_err | m1_ack | m1_err) done_cyc = cyc_n;
         if (pend && cyc_n == done_at) pend = 0;
         if (!oib_clk) begin
            if ((fcnt == 0 || fcnt == fexp) && ob_data != 8'h00) begin
               chk("grant_req", {31'd0, pr0 | pr1}, 32'd1);
               eid = (pr0 && pr1) ? ~last_g : pr1;
               last_g = eid;
               gseq.push_back(eid);
               we  = eid ? m1_we : m0_we;
               sel = eid ? m1_sel : m0_sel;
               adr = eid ? m1_adr : m0_adr;
               dat = eid ? m1_dat_i : m0_dat_i;
               efr[0] = {we, eid, sel, 2'b01};
               for (int j = 0; j < 4; j++) begin
                  efr[1+j] = adr[8*j +: 8];
                  efr[5+j] = dat[8*j +: 8];
               end
               fexp = we ? 9 : 5;
               fr[0] = ob_data;
               chk("frame_hdr", ob_data, efr[0]);
               fcnt = 1; hdr_cyc = cyc_n; ridx = 0;
               crlen = rlen;
               for (int j = 0; j < 16; j++) begin
                  crb[j] = rb[j]; crbad[j] = rbad[j];
               end
               predict(we, cyc_n);
               pend = 1; ab = 0; exp_id = eid; exp_we = we;
               ib_data = 8'h00; ib_pty = 1'b1;
            end else if (fcnt > 0 && fcnt < fexp) begin
               fr[fcnt] = ob_data;
               chk("frame_byte", ob_data, efr[fcnt]);
               fcnt++;
               ib_data = 8'h00; ib_pty = 1'b1;
            end else if (fcnt > 0 && fcnt == fexp) begin
               if (ridx < crlen) begin
                  ib_data = crb[ridx];
                  ib_pty = crbad[ridx] ? ^crb[ridx] : ~^crb[ridx];
               end else begin
                  ib_data = 8'h00; ib_pty = 1'b1;
               end
               ridx++;
            end else begin
               chk("link_idle", ob_data, 8'h00);
            end
         end
         if (pend && cyc_n < done_at && !(exp_id ? m1_cyc : m0_cyc))
            ab = 1;
         pr0 = m0_cyc & m0_stb;
         pr1 = m1_cyc & m1_stb;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit id, input bit on, input bit we,
                        input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
      if (id) begin
         m1_cyc = on; m1_stb = on; m1_we = we;
         m1_sel = sel; m1_adr = adr; m1_dat_i = dat;
      end else begin
         m0_cyc = on; m0_stb = on; m0_we = we;
         m0_sel = sel; m0_adr = adr; m0_dat_i = dat;
      end
   endtask

   task automatic wait_end(input bit id, input int lim);
      bit got = 0;
      for (int i = 0; i < lim && !got; i++) begin
         tick;
         if (id ? (m1_ack | m1_err) : (m0_ack | m0_err)) got = 1;
      end
      chk("done_in_time", {31'd0, got}, 32'd1);
      drive(id, 0, 0, 4'h0, 32'h0, 32'h0);
      tick;
   endtask

   task automatic set_script(input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4,
                             input int badpos);
      rlen = n;
      rb[0] = b0; rb[1] = b1; rb[2] = b2; rb[3] = b3; rb[4] = b4;
      for (int j = 0; j < 16; j++) rbad[j] = (j == badpos);
   endtask

   task automatic clr_counts;
      n_ack0 = 0; n_ack1 = 0; n_err0 = 0; n_err1 = 0;
   endtask

   logic [7:0] lit_w[9];

   initial begin
      int acks;
      bit ok;
      for (int j = 0; j < 16; j++) begin rb[j] = 0; rbad[j] = 0; end
      repeat (4) tick;
      chk("rst_ob_data", ob_data, 8'h00);
      chk("rst_ob_pty", ob_pty, 1'b1);
      chk("rst_oib_clk", oib_clk, 1'b0);
      chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
      chk("rst_dat", m0_dat_o | m1_dat_o, 32'h0);
      rst = 1'b0;
      repeat (3) tick;

      // m0 write
      clr_counts;
      set_script(1, 8'h01, 0, 0, 0, 0, -1);
      drive(0, 1, 1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF);
      wait_end(0, 200);
      lit_w = '{8'hBD, 8'h10, 8'h00, 8'h00, 8'h30,
                8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int j = 0; j < 9; j++) chk("wr_frame_lit", fr[j], lit_w[j]);
      chk("wr_ack_count", n_ack0, 1);
      chk("wr_latency", done_cyc - hdr_cyc, 21);

      // m1 read
      clr_counts;
      set_script(5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, -1);
      drive(1, 1, 0, 4'hF, 32'h0000_0004, 32'h0);
      wait_end(1, 200);
      chk("rd_hdr_lit", fr[0], 8'h7D);
      chk("rd_dat_lit", m1_dat_o, 32'h1234_5678);
      chk("rd_latency", done_cyc - hdr_cyc, 21);
      chk("rd_ack_count", n_ack1, 1);

      // continuous requests from both sides
      clr_counts;
      gseq.delete();
      set_script(1, 8'h01, 0, 0, 0, 0, -1);
      drive(0, 1, 1, 4'h3, 32'h0000_0100, 32'hA5A5_A5A5);
      drive(1, 1, 1, 4'hC, 32'h0000_0200, 32'h5A5A_5A5A);
      acks = 0;
      for (int i = 0; i < 400 && acks < 4; i++) begin
         tick;
         if (m0_ack | m1_ack) acks++;
      end
      drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
      drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
      repeat (2) tick;
      chk("rr_acks", acks, 4);
      chk("rr_grants", gseq.size(), 4);
      if (gseq.size() >= 4) begin
         chk("rr_g0", gseq[0], 1'b0);
         chk("rr_g1", gseq[1], 1'b1);
         chk("rr_g2", gseq[2], 1'b0);
         chk("rr_g3", gseq[3], 1'b1);
      end

      // timeout with idle inbound link
      clr_counts;
      set_script(0, 0, 0, 0, 0, 0, -1);
      drive(0, 1, 1, 4'h1, 32'h0000_0020, 32'h0000_0001);
      wait_end(0, 200);
      chk("to_err_count", n_err0, 1);
      chk("to_ack_count", n_ack0, 0);
      chk("to_latency", done_cyc - hdr_cyc, 27);
      repeat (3) tick;
      chk("to_idle", {ob_pty, ob_data}, 9'h100);

      // read with a parity error on the 3rd data byte
      clr_counts;
      set_script(5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 3);
      drive(1, 1, 0, 4'hF, 32'h0000_0008, 32'h0);
      wait_end(1, 200);
      chk("pe_err_count", n_err1, 1);
      chk("pe_dat_kept", m1_dat_o, 32'h1234_5678);

      // error response header
      clr_counts;
      set_script(1, 8'h05, 0, 0, 0, 0, -1);
      drive(1, 1, 1, 4'h2, 32'h0000_000C, 32'h0000_0077);
      wait_end(1, 200);
      chk("er_err_count", n_err1, 1);

      // reset in the middle of the outbound frame
      set_script(1, 8'h01, 0, 0, 0, 0, -1);
      drive(0, 1, 1, 4'hF, 32'h0000_0040, 32'h1111_2222);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick;
         if (fcnt >= 3) ok = 1;
      end
      chk("mid_send_reached", {31'd0, ok}, 32'd1);
      rst = 1'b1;
      drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
      tick;
      chk("mr_ob_data", ob_data, 8'h00);
      chk("mr_ob_pty", ob_pty, 1'b1);
      chk("mr_acks", {m0_ack, m0_err, m1_ack, m1_err}, 4'h0);
      tick;
      rst = 1'b0;
      repeat (2) tick;
      clr_counts;
      set_script(5, 8'h01, 8'h0D, 8'hF0, 8'hFE, 8'hCA, -1);
      drive(1, 1, 0, 4'hF, 32'h0000_0050, 32'h0);
      wait_end(1, 200);
      chk("mr_fresh_dat", m1_dat_o, 32'hCAFE_F00D);
      chk("mr_fresh_ack", n_ack1, 1);

      // m0 drops cyc while waiting for the response
      clr_counts;
      set_script(3, 8'h00, 8'h00, 8'h01, 0, 0, -1);
      drive(0, 1, 1, 4'hF, 32'h0000_0060, 32'h3333_4444);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick;
         if (fcnt > 0) ok = 1;
      end
      set_script(5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, -1);
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick;
         if (fcnt == 9) ok = 1;
      end
      chk("ab_wait_reached", {31'd0, ok}, 32'd1);
      drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
      drive(1, 1, 0, 4'hF, 32'h0000_0070, 32'h0);
      wait_end(1, 200);
      chk("ab_no_m0", n_ack0 + n_err0, 0);
      chk("ab_m1_ack", n_ack1, 1);
      chk("ab_m1_dat", m1_dat_o, 32'h4433_2211);
      chk("ab_last_grant", gseq[gseq.size()-1], 1'b1);

      repeat (4) tick;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/oib_link_arbiter.md
Name: oib_link_arbiter

Overview:
- Round-robin arbiter and serializer for the 8-bit parity-protected off-chip byte link (oib_clk / ob_data / ob_pty out, ib_data / ib_pty in).
- Shares the link between two 32-bit Wishbone-style requesters: m0 = management-SoC Wishbone slave path, m1 = core-side master.
- Each granted request is framed into bytes, sent outbound, and its response byte (and read data) is collected back.
- Sits in the user project between the requesters and the GPIO pads 18-36.

Parameters:
- TIMEOUT, 255, max byte slots to wait in S_WAIT for a response header before signalling error (1..255).

Ports:
- wb_clk_i  input  1  single clock; all logic is rising-edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- m0_cyc, m1_cyc  input  1 each  bus cycle active.
- m0_stb, m1_stb  input  1 each  request strobe.
- m0_we, m1_we  input  1 each  1 = write.
- m0_sel, m1_sel  input  4 each  byte selects.
- m0_adr, m1_adr  input  32 each  byte address.
- m0_dat_i, m1_dat_i  input  32 each  write data.
- m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
- m0_err, m1_err  output  1 each  one-cycle error pulse (timeout, parity, or error response).
- m0_dat_o, m1_dat_o  output  32 each  read data; valid in the ack cycle and held until the next completion.
- oib_clk  output  1  link clock, registered.
- ob_data  output  8  outbound byte.
- ob_pty  output  1  outbound odd parity, = ~^ob_data.
- ib_data  input  8  inbound byte.
- ib_pty  input  1  inbound odd parity.

Behaviour:
- Reset values: oib_clk=0, ob_data=0x00, ob_pty=1, all ack/err=0, dat_o=0, state S_IDLE, last_grant=m1 (so m0 wins the first tie).
- Byte slot = 2 cycles, counted by a phase bit.
  - Phase 0: oib_clk=0; ob_data/ob_pty update at the start of this phase.
  - Phase 1: oib_clk=1; ib_data/ib_pty are sampled at the end of this phase.
  - The phase bit free-runs from reset.
- Idle link: ob_data=0x00, ob_pty=1. Inbound 0x00 with ib_pty=1 means idle.
- Request pending: mX_cyc & mX_stb.
- Arbitration, in S_IDLE at a slot boundary (phase about to become 0):
  - One request pending: grant it.
  - Both pending: grant the one that is not last_grant.
  - Grant latches we, sel, adr and dat_i into shadow registers and updates last_grant.
  - A request that arrives mid-slot waits for the next boundary.
- Outbound frame, sent in S_SEND:
  - Header byte = {we, 1'b0, 1'b0, grant_id, sel[3:1]... } is not used; header = {we, grant_id, 2'b00, sel} is not used either. Header is defined as: bit7 = we, bit6 = grant_id, bits5:2 = sel, bit1 = 0, bit0 = 1. Bit0 = 1 guarantees the header is never 0x00.
  - Then adr[7:0], adr[15:8], adr[23:16], adr[31:24].
  - Writes then send dat[7:0] through dat[31:24].
  - Byte counter is 4 bits: 5 bytes for a read, 9 for a write.
- S_WAIT:
  - Outbound returns to idle.
  - Each phase-1 sample checks the inbound byte.
  - Parity error (ib_pty != ~^ib_data): go to S_DONE with err.
  - 0x00 with good parity: increment the slot counter; when the counter reaches TIMEOUT, go to S_DONE with err.
  - 0x01: write goes to S_DONE with ack; read goes to S_RECV.
  - Any other nonzero value: go to S_DONE with err.
- S_RECV:
  - Capture 4 bytes LSB-first into the shadow read register, one per slot.
  - Idle bytes are not permitted here: each slot's byte is taken as data.
  - A parity error on any byte goes to S_DONE with err.
- S_DONE (one cycle):
  - Pulse the granted requester's ack or err.
  - On ack for a read, load its dat_o from the shadow register.
  - Then go to S_IDLE.
- Requester abort: if the granted requester drops cyc before S_DONE, the frame still completes on the link, and the ack/err pulse is suppressed. Required so the link stays framed.
- Only the granted requester ever sees ack/err. The non-granted requester waits with no timeout of its own.
- wb_rst_i asserted mid-frame: everything returns to reset values on the next edge. The outbound byte goes idle immediately, with no partial-frame completion.
- Latency from grant to ack, with the response header arriving in the first wait slot:
  - Write: (9 + 1) × 2 + 1 = 21 cycles.
  - Read: (5 + 1 + 4) × 2 + 1 = 21 cycles.

Test Plan:
- m0 write adr=0x3000_0010, dat=0xDEADBEEF, sel=0xF; bench replies 0x01 in the first wait slot.
  - Outbound bytes: 0xBD, 0x10, 0x00, 0x00, 0x30, 0xEF, 0xBE, 0xAD, 0xDE, each with odd parity.
  - m0_ack pulses once, 21 cycles after grant.
- m1 read adr=0x0000_0004, sel=0xF; bench replies 0x01, 0x78, 0x56, 0x34, 0x12.
  - Header = 0x7D.
  - m1_dat_o = 0x12345678 in the ack cycle.
- m0 and m1 request continuously, starting on the same cycle.
  - Grants alternate m0, m1, m0, m1.
  - No requester receives two consecutive grants.
- TIMEOUT=4, bench holds the inbound link idle.
  - m0_err pulses after exactly 4 wait slots.
  - The link returns to idle; no ack is issued.
- Read where the bench flips ib_pty on the 3rd data byte: err pulse, m1_dat_o unchanged.
- Two aborted transactions:
  - Assert wb_rst_i mid-S_SEND: ob_data=0x00, ob_pty=1 on the next cycle; a fresh request then proceeds normally.
  - Drop m0_cyc during S_WAIT: no m0_ack; the next m1 request is granted after the frame ends.
